ps2_key_decoder: RTL and testbench

//  Downstream of the PS/2 receiver. Takes each received scan-code byte (set 2), tracks E0/F0 prefixes,
//  and produces two outputs: a level bitmap of held game keys (WASD, arrows, space, enter, esc) and a

---
 rtl/ps2_key_decoder.sv | 137 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes, keeps a held-key bitmap for the
// game keys and buffers one make/break event for the consumer.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int TMO_WIDTH      = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode,
   input  logic        key_valid,
   output logic [10:0] keys_down,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [7:0]  ev_code,
   output logic        ev_ext,
   output logic        ev_break,
   output logic        ev_overflow
);

   // state    | meaning
   // IDLE     | no prefix pending
   // EXT      | E0 received
   // BRK      | F0 received
   // EXT_BRK  | E0 then F0 received
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state, state_next;
   logic [TMO_WIDTH-1:0] tmo_cnt, tmo_next;
   logic [7:0]           rx_byte;
   logic                 cur_ext, cur_brk;
   logic                 ev_done;
   logic [10:0]          key_mask;
   logic [10:0]          keys_next;
   logic                 unused_keycode_hi;

   assign rx_byte           = keycode[7:0];
   assign unused_keycode_hi = ^keycode[15:8];
   assign cur_ext           = (state == ST_EXT) || (state == ST_EXT_BRK);
   assign cur_brk           = (state == ST_BRK) || (state == ST_EXT_BRK);

   always_comb begin
      state_next = state;
      tmo_next   = '0;
      ev_done    = 1'b0;
      if (key_valid) begin
         unique case (rx_byte)
            8'hE0: state_next = ST_EXT;
            8'hF0: begin
               if (state == ST_IDLE)     state_next = ST_BRK;
               else if (state == ST_EXT) state_next = ST_EXT_BRK;
               else                      state_next = state;
            end
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_next = ST_IDLE;
            default: begin
               ev_done    = 1'b1;
               state_next = ST_IDLE;
            end
         endcase
      end else if (state != ST_IDLE) begin
         if (tmo_cnt == TMO_LAST) begin
            state_next = ST_IDLE;
         end else begin
            tmo_next = tmo_cnt + 1'b1;
         end
      end
   end

   // The E0 flag is part of the key identity: plain 75 is keypad 8, not UP.
   always_comb begin
      key_mask = '0;
      unique case ({cur_ext, rx_byte})
         {1'b0, 8'h1D}: key_mask[0]  = 1'b1;
         {1'b0, 8'h1C}: key_mask[1]  = 1'b1;
         {1'b0, 8'h1B}: key_mask[2]  = 1'b1;
         {1'b0, 8'h23}: key_mask[3]  = 1'b1;
         {1'b1, 8'h75}: key_mask[4]  = 1'b1;
         {1'b1, 8'h6B}: key_mask[5]  = 1'b1;
         {1'b1, 8'h72}: key_mask[6]  = 1'b1;
         {1'b1, 8'h74}: key_mask[7]  = 1'b1;
         {1'b0, 8'h29}: key_mask[8]  = 1'b1;
         {1'b0, 8'h5A}: key_mask[9]  = 1'b1;
         {1'b0, 8'h76}: key_mask[10] = 1'b1;
         default:       key_mask     = '0;
      endcase
   end

   always_comb begin
      keys_next = keys_down;
      if (ev_done) begin
         if (cur_brk) keys_next = keys_down & ~key_mask;
         else         keys_next = keys_down | key_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         keys_down <= '0;
      end else begin
         state     <= state_next;
         tmo_cnt   <= tmo_next;
         keys_down <= keys_next;
      end
   end

   // Single-entry buffer; a pop and a push in the same cycle keep it full without loss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_valid    <= 1'b0;
         ev_code     <= '0;
         ev_ext      <= 1'b0;
         ev_break    <= 1'b0;
         ev_overflow <= 1'b0;
      end else begin
         if (ev_done && (!ev_valid || ev_ready)) begin
            ev_valid <= 1'b1;
            ev_code  <= rx_byte;
            ev_ext   <= cur_ext;
            ev_break <= cur_brk;
         end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
         end
         if (ev_done && ev_valid && !ev_ready) begin
            ev_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: reset, make/break, extended keys, backpressure,
// prefix timeout and discard codes, with hand-computed expectations.
module tb_ps2_key_decoder;

   localparam int TMO = 16;

   logic        clk;
   logic        rst;
   logic [15:0] keycode;
   logic        key_valid;
   logic [10:0] keys_down;
   logic        ev_valid;
   logic        ev_ready;
   logic [7:0]  ev_code;
   logic        ev_ext;
   logic        ev_break;
   logic        ev_overflow;

   int tests = 0;
   int fails = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .TMO_WIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .keycode     (keycode),
      .key_valid   (key_valid),
      .keys_down   (keys_down),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_code     (ev_code),
      .ev_ext      (ev_ext),
      .ev_break    (ev_break),
      .ev_overflow (ev_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Strobes one byte for one cycle; returns at the following negedge, where the result is visible.
   task automatic send(input logic [7:0] b, input logic rdy);
      @(negedge clk);
      keycode   = {8'h5A, b};
      key_valid = 1'b1;
      ev_ready  = rdy;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic check_ev(input string tag, input logic [7:0] code, input logic ext, input logic brk);
      check({tag, "_valid"}, {15'd0, ev_valid}, 16'd1);
      check({tag, "_code"},  {8'd0, ev_code},   {8'd0, code});
      check({tag, "_ext"},   {15'd0, ev_ext},   {15'd0, ext});
      check({tag, "_brk"},   {15'd0, ev_break}, {15'd0, brk});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_keys", {5'd0, keys_down}, 16'h0000);
      check("rst_outs", {11'd0, ev_valid, ev_code == 8'd0, ev_ext, ev_break, ev_overflow}, 16'h0008);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      keycode   = '0;
      key_valid = 1'b0;
      ev_ready  = 1'b1;
      repeat (2) @(negedge clk);
      check("init_keys", {5'd0, keys_down}, 16'h0000);
      check("init_valid", {15'd0, ev_valid}, 16'd0);
      rst = 1'b0;

      // reset mid-sequence (state would be EXT_BRK)
      send(8'hE0, 1'b1);
      send(8'hF0, 1'b1);
      do_reset();
      send(8'h1D, 1'b1);
      check("t1_keys", {5'd0, keys_down}, 16'h0001);
      check_ev("t1_ev", 8'h1D, 1'b0, 1'b0);

      // make/break W
      send(8'hF0, 1'b1);
      check("t2_pfx_keys", {5'd0, keys_down}, 16'h0001);
      check("t2_pfx_valid", {15'd0, ev_valid}, 16'd0);
      send(8'h1D, 1'b1);
      check("t2_brk_keys", {5'd0, keys_down}, 16'h0000);
      check_ev("t2_brk_ev", 8'h1D, 1'b0, 1'b1);
      send(8'h1D, 1'b1);
      send(8'h1D, 1'b1);
      check("t2_typematic", {5'd0, keys_down}, 16'h0001);
      send(8'hF0, 1'b1);
      send(8'h1D, 1'b1);
      check("t2_rel", {5'd0, keys_down}, 16'h0000);

      // extended keys
      send(8'hE0, 1'b1);
      send(8'h75, 1'b1);
      check("t3_up_keys", {5'd0, keys_down}, 16'h0010);
      check_ev("t3_up_ev", 8'h75, 1'b1, 1'b0);
      send(8'hE0, 1'b1);
      send(8'hF0, 1'b1);
      send(8'h75, 1'b1);
      check("t3_uprel_keys", {5'd0, keys_down}, 16'h0000);
      check_ev("t3_uprel_ev", 8'h75, 1'b1, 1'b1);
      send(8'h75, 1'b1);
      check("t3_kp8_keys", {5'd0, keys_down}, 16'h0000);
      check_ev("t3_kp8_ev", 8'h75, 1'b0, 1'b0);

      // backpressure: second event dropped
      send(8'h1C, 1'b0);
      check_ev("t4_first", 8'h1C, 1'b0, 1'b0);
      send(8'h23, 1'b0);
      check_ev("t4_hold", 8'h1C, 1'b0, 1'b0);
      check("t4_ovf", {15'd0, ev_overflow}, 16'd1);
      check("t4_keys", {13'd0, keys_down[3:1]}, 16'h0005);
      repeat (3) @(negedge clk);
      check("t4_stable", {8'd0, ev_code}, 16'h001C);
      check("t4_ovf_sticky", {15'd0, ev_overflow}, 16'd1);

      // pop and push in the same cycle
      do_reset();
      send(8'h1C, 1'b0);
      send(8'h23, 1'b1);
      check_ev("t4_pp", 8'h23, 1'b0, 1'b0);
      check("t4_pp_ovf", {15'd0, ev_overflow}, 16'd0);
      check("t4_pp_keys", {5'd0, keys_down}, 16'h000A);
      @(negedge clk);
      check("t4_popped", {15'd0, ev_valid}, 16'd0);

      // prefix timeout: TMO idle cycles after F0 (send() already supplies one)
      send(8'hF0, 1'b1);
      repeat (TMO - 1) @(negedge clk);
      send(8'h1B, 1'b1);
      check("t5_to_keys", {5'd0, keys_down}, 16'h000E);
      check_ev("t5_to_ev", 8'h1B, 1'b0, 1'b0);
      // one cycle short of the timeout keeps the prefix
      send(8'hF0, 1'b1);
      repeat (TMO - 2) @(negedge clk);
      send(8'h1B, 1'b1);
      check("t5_nto_keys", {5'd0, keys_down}, 16'h000A);
      check_ev("t5_nto_ev", 8'h1B, 1'b0, 1'b1);

      // discard codes
      send(8'h29, 1'b1);
      check("t6_space", {5'd0, keys_down}, 16'h010A);
      send(8'hAA, 1'b1);
      check("t6_aa", {15'd0, ev_valid}, 16'd0);
      send(8'hFA, 1'b1);
      check("t6_fa", {15'd0, ev_valid}, 16'd0);
      send(8'hE0, 1'b1);
      send(8'hFE, 1'b1);
      check("t6_fe", {15'd0, ev_valid}, 16'd0);
      send(8'hF0, 1'b1);
      send(8'h29, 1'b1);
      check("t6_rel_keys", {5'd0, keys_down}, 16'h000A);
      check_ev("t6_rel_ev", 8'h29, 1'b0, 1'b1);

      // remaining map entries
      send(8'h76, 1'b1);
      check("map_esc", {5'd0, keys_down}, 16'h040A);
      send(8'h5A, 1'b1);
      check("map_enter", {5'd0, keys_down}, 16'h060A);
      send(8'hE0, 1'b1);
      send(8'h6B, 1'b1);
      check("map_left", {5'd0, keys_down}, 16'h062A);
      send(8'hE0, 1'b1);
      send(8'h72, 1'b1);
      check("map_down", {5'd0, keys_down}, 16'h066A);
      send(8'hE0, 1'b1);
      send(8'h74, 1'b1);
      check("map_right", {5'd0, keys_down}, 16'h06EA);
      send(8'hE0, 1'b1);
      send(8'h1D, 1'b1);
      check("map_extw", {5'd0, keys_down}, 16'h06EA);
      check_ev("map_extw_ev", 8'h1D, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
